// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-masked RAM front-end.
// The request struct is sized for the default geometry.
package ram_pkg;

  localparam int RSP_DEPTH_MIN   = 2;
  localparam int DATA_WIDTH_DFLT = 32;
  localparam int DEPTH_DFLT      = 16;

  function automatic int bwen_width(input int data_width);
    return data_width / 8;
  endfunction

  localparam int BWEN_WIDTH_DFLT = bwen_width(DATA_WIDTH_DFLT);
  localparam int ADDR_WIDTH_DFLT = $clog2(DEPTH_DFLT);

  typedef struct packed {
    logic                       wen;
    logic [BWEN_WIDTH_DFLT-1:0] bwen;
    logic [ADDR_WIDTH_DFLT-1:0] addr;
    logic [DATA_WIDTH_DFLT-1:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_sp_bytemask.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Contents and dout are intentionally not reset.
module ram_sp_bytemask
  import ram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BWEN_WIDTH = bwen_width(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_cen,
  input  logic                  i_wen,
  input  logic [BWEN_WIDTH-1:0] i_bwen,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge i_clk) begin
    if (i_cen) begin
      if (i_wen) begin
        for (int i = 0; i < BWEN_WIDTH; i++) begin
          if (i_bwen[i]) r_mem[i_addr][8*i +: 8] <= i_din[8*i +: 8];
        end
      end else begin
        r_dout <= r_mem[i_addr];
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/ram_sp_bytemask_ctrl.sv
// Valid/ready front-end for the byte-masked RAM: credit-limited reads feed
// an inline response FIFO so read data survives consumer backpressure.
module ram_sp_bytemask_ctrl
  import ram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  parameter  int RSP_DEPTH  = 3,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BWEN_WIDTH = bwen_width(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [BWEN_WIDTH-1:0] req_bwen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy
);

  localparam int FIFO_DEPTH = (RSP_DEPTH < RSP_DEPTH_MIN) ? RSP_DEPTH_MIN : RSP_DEPTH;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  // one spare bit so count + rd_pend cannot overflow in the credit compare
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1) + 1;

  logic                  w_cen;
  logic                  w_rd_acc;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_ram_dout;

  logic                  r_rd_pend;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign req_ready = req_wen | ((r_count + CNT_W'(r_rd_pend)) < CNT_W'(FIFO_DEPTH));
  assign w_cen     = req_valid & req_ready;
  assign w_rd_acc  = w_cen & ~req_wen;
  assign w_push    = r_rd_pend;
  assign w_pop     = rsp_valid & rsp_ready;
  assign rsp_valid = (r_count != '0);
  assign rsp_rdata = r_fifo[r_rd_ptr];
  assign busy      = r_rd_pend | rsp_valid;

  ram_sp_bytemask #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .i_clk  (clock),
    .i_cen  (w_cen),
    .i_wen  (req_wen),
    .i_bwen (req_bwen),
    .i_addr (req_addr),
    .i_din  (req_wdata),
    .o_dout (w_ram_dout)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_rd_pend <= w_rd_acc;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_ram_dout;
  end

  // The read credit check must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(w_push && (r_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_ram_sp_bytemask_ctrl.sv
// Scoreboard bench: driver pushes expected read data from a flat memory model,
// a monitor pops and compares on every response handshake.
module tb_ram_sp_bytemask_ctrl;
  import ram_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int RSPD  = 3;
  localparam int AW    = 4;
  localparam int BW    = 4;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wen = 1'b0;
  logic [BW-1:0] req_bwen = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          busy;

  ram_sp_bytemask_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RSP_DEPTH(RSPD)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_bwen  (req_bwen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    bit            chk_lat;
    int            acc_cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model [DEPTH];
  int            n_err = 0;
  int            n_chk = 0;

  task automatic check_eq(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_req(input req_t r, input bit no_stall, input bit chk_lat,
                        input bit use_exp, input logic [DW-1:0] exp_data);
    int   waits;
    exp_t e;
    waits     = 0;
    req_valid = 1'b1;
    req_wen   = r.wen;
    req_bwen  = r.bwen;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    @(negedge clock);
    while (!req_ready) begin
      waits++;
      if (waits > 200) begin
        n_chk++;
        n_err++;
        $display("FAIL req_accept_timeout: got no ready, expected accept (addr %0d)", r.addr);
        req_valid = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
      if (waits > 3) rsp_ready = 1'b1;
      @(negedge clock);
    end
    if (no_stall) check_eq("req_ready_no_stall", DW'(waits), 0);
    if (r.wen) begin
      for (int i = 0; i < BW; i++)
        if (r.bwen[i]) model[r.addr][8*i +: 8] = r.wdata[8*i +: 8];
    end else begin
      e.data    = use_exp ? exp_data : model[r.addr];
      e.chk_lat = chk_lat;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] data, input logic [BW-1:0] bwen,
                    input bit no_stall);
    req_t r;
    r.wen = 1'b1; r.bwen = bwen; r.addr = AW'(addr); r.wdata = data;
    do_req(r, no_stall, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input int addr, input bit no_stall, input bit chk_lat,
                    input bit use_exp, input logic [DW-1:0] exp_data);
    req_t r;
    r.wen = 1'b0; r.bwen = '0; r.addr = AW'(addr); r.wdata = $urandom;
    do_req(r, no_stall, chk_lat, use_exp, exp_data);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clock);
      t++;
    end
    @(posedge clock);
    #1;
    check_eq("drain_queue_empty", DW'(exp_q.size()), 0);
    check_eq("drain_rsp_valid", DW'(rsp_valid), 0);
    check_eq("drain_busy", DW'(busy), 0);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clock);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: got %h, expected no response (cycle %0d)", rsp_rdata, cyc);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_rdata", rsp_rdata, e.data);
          if (e.chk_lat) check_eq("rsp_latency", DW'(cyc - e.acc_cyc), 2);
        end
      end
    end
  endtask

  task automatic run_tests();
    // reset state
    #1;
    check_eq("reset_rsp_valid", DW'(rsp_valid), 0);
    check_eq("reset_busy", DW'(busy), 0);
    check_eq("reset_req_ready_rd", DW'(req_ready), 1);
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    for (int a = 0; a < DEPTH; a++) wr(a, $urandom, 4'hF, 1'b1);

    // full write then read, 2-cycle latency
    wr(3, 32'hDEADBEEF, 4'hF, 1'b1);
    rd(3, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    wait_drain();

    // partial byte write
    wr(5, 32'h11223344, 4'hF, 1'b1);
    wr(5, 32'hAABBCCDD, 4'h5, 1'b1);
    rd(5, 1'b1, 1'b1, 1'b1, 32'h11BB33DD);
    wait_drain();

    // backpressure: three reads fit, the fourth is held off
    rsp_ready = 1'b0;
    for (int a = 0; a < 3; a++) rd(a, 1'b1, 1'b0, 1'b0, '0);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = AW'(3);
    repeat (3) begin
      @(negedge clock);
      check_eq("req_ready_full", DW'(req_ready), 0);
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    rd(3, 1'b0, 1'b0, 1'b0, '0);
    wait_drain();

    // eight back-to-back reads at full throughput
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) rd($urandom_range(0, DEPTH-1), 1'b1, 1'b1, 1'b0, '0);
    wait_drain();

    // reset with two buffered responses and one read in flight
    rsp_ready = 1'b0;
    rd(1, 1'b1, 1'b0, 1'b0, '0);
    rd(2, 1'b1, 1'b0, 1'b0, '0);
    rd(4, 1'b1, 1'b0, 1'b0, '0);
    check_eq("pre_reset_rsp_valid", DW'(rsp_valid), 1);
    check_eq("pre_reset_busy", DW'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_reset_rsp_valid", DW'(rsp_valid), 0);
    check_eq("mid_reset_busy", DW'(busy), 0);
    exp_q.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check_eq("post_reset_rsp_valid", DW'(rsp_valid), 0);
    check_eq("post_reset_busy", DW'(busy), 0);

    // writes still flow while the response FIFO is full
    rsp_ready = 1'b0;
    for (int a = 0; a < 3; a++) rd(a + 9, 1'b1, 1'b0, 1'b0, '0);
    wr(7, 32'h0707A5A5, 4'hF, 1'b1);
    wr(8, 32'h08085A5A, 4'hF, 1'b1);
    check_eq("fifo_full_rsp_valid", DW'(rsp_valid), 1);
    rsp_ready = 1'b1;
    rd(7, 1'b0, 1'b0, 1'b1, 32'h0707A5A5);
    rd(8, 1'b0, 1'b0, 1'b1, 32'h08085A5A);
    wait_drain();

    // random mix with random consumer backpressure
    for (int k = 0; k < 300; k++) begin
      req_t r;
      rsp_ready = ($urandom_range(0, 3) != 0);
      r.wen   = $urandom_range(0, 1);
      r.bwen  = BW'($urandom_range(0, 15));
      r.addr  = AW'($urandom_range(0, DEPTH-1));
      r.wdata = $urandom;
      do_req(r, r.wen, 1'b0, 1'b0, '0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
    end
    wait_drain();
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    fork
      monitor_loop();
      run_tests();
      begin
        #400000;
        n_chk++;
        n_err++;
        $display("FAIL global_timeout: got no completion, expected finish by 400000");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
